// File: rtl/sync_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_if
// Description : Handshake/status bundle for sync_fifo. The "master" modport is
//               the producer/consumer side, the "slave" modport is the FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
interface sync_fifo_if #(
    parameter int AW = 3,
    parameter int DW = 32
);
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic          afull;
    logic          aempty;
    logic [AW:0]   afull_th;
    logic [AW:0]   aempty_th;
    logic [AW:0]   level;
    logic          overflow;
    logic          underflow;
    logic          flag_clr;
    logic [AW:0]   peak_level;

    modport master (
        output wr_en, wr_data, rd_en, afull_th, aempty_th, flag_clr,
        input  rd_data, rd_valid, full, empty, afull, aempty, level,
               overflow, underflow, peak_level
    );

    modport slave (
        input  wr_en, wr_data, rd_en, afull_th, aempty_th, flag_clr,
        output rd_data, rd_valid, full, empty, afull, aempty, level,
               overflow, underflow, peak_level
    );
endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO, depth 2**AW, with first-word-fall-through
//               (FWFT=1) or registered-read (FWFT=0) output, runtime
//               almost-full/almost-empty thresholds, exact fill level and
//               sticky overflow/underflow flags.
//               Optional macro SYNC_FIFO_WMARK_EN adds a high-water-mark
//               register on peak_level; otherwise peak_level is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int AW   = 3,
    parameter int DW   = 32,
    parameter int FWFT = 1
) (
    input wire          clk,
    input wire          reset,
    sync_fifo_if.slave  bus
);

    localparam int          DP      = 1 << AW;
    // Level value meaning "completely full" (MSB set, rest clear).
    localparam logic [AW:0] c_depth = {1'b1, {AW{1'b0}}};

    // Pointers carry one extra wrap bit so that full and empty differ.
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    // Storage is deliberately not reset.
    logic [DW-1:0] mem_q [DP];

    logic [AW:0]   w_level;
    logic          w_full;
    logic          w_empty;
    logic          w_wr_acc;
    logic          w_rd_acc;

    // Occupancy and accept decisions, all from start-of-cycle state.
    always_comb begin
        w_level  = wr_ptr_q - rd_ptr_q;
        w_full   = (w_level == c_depth);
        w_empty  = (w_level == '0);
        w_wr_acc = bus.wr_en & ~w_full;
        w_rd_acc = bus.rd_en & ~w_empty;
    end

    // Next pointers and sticky error flags; a new error beats flag_clr.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (w_wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (bus.flag_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (bus.wr_en && w_full) begin
            overflow_d = 1'b1;
        end
        if (bus.rd_en && w_empty) begin
            underflow_d = 1'b1;
        end
    end

    // Pointer and flag registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage write on accepted write only.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            mem_q[wr_ptr_q[AW-1:0]] <= bus.wr_data;
        end
    end

    // Read-side presentation depends on the selected read mode.
    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is visible combinationally whenever data is held.
            assign bus.rd_data  = mem_q[rd_ptr_q[AW-1:0]];
            assign bus.rd_valid = ~w_empty;
        end else begin : g_reg_read
            logic [DW-1:0] rd_data_q, rd_data_d;
            logic          rd_valid_q, rd_valid_d;

            // Capture the popped word; hold the last value otherwise.
            always_comb begin
                rd_data_d  = rd_data_q;
                rd_valid_d = w_rd_acc;
                if (w_rd_acc) begin
                    rd_data_d = mem_q[rd_ptr_q[AW-1:0]];
                end
            end

            // Read data register, one cycle after the accepted read.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_data_q  <= rd_data_d;
                    rd_valid_q <= rd_valid_d;
                end
            end

            assign bus.rd_data  = rd_data_q;
            assign bus.rd_valid = rd_valid_q;
        end
    endgenerate

`ifdef SYNC_FIFO_WMARK_EN
    logic [AW:0] peak_level_q, peak_level_d;

    // High-water mark follows the registered level, so it lags it by a cycle.
    always_comb begin
        peak_level_d = peak_level_q;
        if (bus.flag_clr) begin
            peak_level_d = w_level;
        end else if (w_level > peak_level_q) begin
            peak_level_d = w_level;
        end
    end

    // High-water-mark register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            peak_level_q <= '0;
        end else begin
            peak_level_q <= peak_level_d;
        end
    end

    assign bus.peak_level = peak_level_q;
`else
    assign bus.peak_level = '0;
`endif

    // Status outputs; thresholds are compared live every cycle.
    assign bus.level     = w_level;
    assign bus.full      = w_full;
    assign bus.empty     = w_empty;
    assign bus.afull     = (w_level >= bus.afull_th);
    assign bus.aempty    = (w_level <= bus.aempty_th);
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo
// Description : Self-checking bench for sync_fifo. One FWFT=1 and one FWFT=0
//               instance share the same stimulus; a queue-based model gives
//               the expected level, flags and data. Honours SYNC_FIFO_WMARK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo;

    localparam int AW = 3;
    localparam int DW = 32;
    localparam int DP = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en, rd_en, flag_clr;
    logic [DW-1:0] wr_data;
    logic [AW:0]   afull_th, aempty_th;

    always #5 clk = ~clk;

    sync_fifo_if #(.AW(AW), .DW(DW)) bus1 ();
    sync_fifo_if #(.AW(AW), .DW(DW)) bus0 ();

    assign bus1.wr_en     = wr_en;
    assign bus1.wr_data   = wr_data;
    assign bus1.rd_en     = rd_en;
    assign bus1.flag_clr  = flag_clr;
    assign bus1.afull_th  = afull_th;
    assign bus1.aempty_th = aempty_th;
    assign bus0.wr_en     = wr_en;
    assign bus0.wr_data   = wr_data;
    assign bus0.rd_en     = rd_en;
    assign bus0.flag_clr  = flag_clr;
    assign bus0.afull_th  = afull_th;
    assign bus0.aempty_th = aempty_th;

    sync_fifo #(.AW(AW), .DW(DW), .FWFT(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    sync_fifo #(.AW(AW), .DW(DW), .FWFT(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

    // ---------------- reference model ----------------
    logic [DW-1:0] q[$];
    bit            m_ovf, m_unf, m_rv;
    int            m_peak;
    logic [DW-1:0] m_rd;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        int lvl;
        int exp_pk;
        lvl = q.size();
`ifdef SYNC_FIFO_WMARK_EN
        exp_pk = m_peak;
`else
        exp_pk = 0;
`endif
        chk($sformatf("c%0d level1", cyc), bus1.level, lvl);
        chk($sformatf("c%0d level0", cyc), bus0.level, lvl);
        chk($sformatf("c%0d full", cyc), {bus1.full, bus0.full}, {2{lvl == DP}});
        chk($sformatf("c%0d empty", cyc), {bus1.empty, bus0.empty}, {2{lvl == 0}});
        chk($sformatf("c%0d afull", cyc), {bus1.afull, bus0.afull}, {2{lvl >= int'(afull_th)}});
        chk($sformatf("c%0d aempty", cyc), {bus1.aempty, bus0.aempty}, {2{lvl <= int'(aempty_th)}});
        chk($sformatf("c%0d overflow", cyc), {bus1.overflow, bus0.overflow}, {2{m_ovf}});
        chk($sformatf("c%0d underflow", cyc), {bus1.underflow, bus0.underflow}, {2{m_unf}});
        chk($sformatf("c%0d peak1", cyc), bus1.peak_level, exp_pk);
        chk($sformatf("c%0d peak0", cyc), bus0.peak_level, exp_pk);
        chk($sformatf("c%0d fwft_valid", cyc), bus1.rd_valid, lvl != 0);
        if (lvl != 0) chk($sformatf("c%0d fwft_data", cyc), bus1.rd_data, q[0]);
        chk($sformatf("c%0d reg_valid", cyc), bus0.rd_valid, m_rv);
        chk($sformatf("c%0d reg_data", cyc), bus0.rd_data, m_rd);
    endtask

    // One clock cycle: drive at negedge, advance model at posedge, check #1 after.
    task automatic cycle(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
        int  lvl;
        bit  wacc, racc;
        @(negedge clk);
        wr_en = w; wr_data = d; rd_en = r; flag_clr = c;
        lvl  = q.size();
        wacc = w && (lvl != DP);
        racc = r && (lvl != 0);
        @(posedge clk);
        cyc++;
        m_ovf  = (w && lvl == DP) || (m_ovf && !c);
        m_unf  = (r && lvl == 0) || (m_unf && !c);
        m_peak = c ? lvl : ((lvl > m_peak) ? lvl : m_peak);
        m_rv   = racc;
        if (racc) m_rd = q.pop_front();
        if (wacc) q.push_back(d);
        #1;
        check_all();
    endtask

    // Asynchronous reset pulse between clock edges, checked before any edge.
    task automatic do_reset(input bit keep_wr);
        @(negedge clk);
        wr_en = keep_wr; rd_en = 1'b0; flag_clr = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst empty", {bus1.empty, bus0.empty}, 2'b11);
        chk("rst level", {bus1.level, bus0.level}, 8'h00);
        chk("rst peak", {bus1.peak_level, bus0.peak_level}, 8'h00);
        chk("rst reg_valid", bus0.rd_valid, 1'b0);
        q.delete();
        m_ovf = 0; m_unf = 0; m_rv = 0; m_peak = 0; m_rd = '0;
        @(negedge clk);
        wr_en = 1'b0;
        reset = 1'b0;
        #1;
        check_all();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          wr, rd, clr;
        logic [31:0] wd;
        int          lvl;
        bit          full, empty, ovf, unf, rv0;
        logic [31:0] rd0, head;
    } vec_t;

    function automatic vec_t mk(bit wr, bit rd, bit clr, logic [31:0] wd, int lvl, bit full,
                                bit empty, bit ovf, bit unf, bit rv0, logic [31:0] rd0,
                                logic [31:0] head);
        vec_t v;
        v.wr = wr; v.rd = rd; v.clr = clr; v.wd = wd; v.lvl = lvl; v.full = full;
        v.empty = empty; v.ovf = ovf; v.unf = unf; v.rv0 = rv0; v.rd0 = rd0; v.head = head;
        return v;
    endfunction

    vec_t tbl[21];

    initial begin
        reset = 1'b1; wr_en = 0; rd_en = 0; flag_clr = 0; wr_data = '0;
        afull_th = 4'd6; aempty_th = 4'd1;
        q.delete(); m_ovf = 0; m_unf = 0; m_rv = 0; m_peak = 0; m_rd = '0;

        // Fill 0..7, drop a 9th write, drain 8, read on empty, then
        // registered-read latency check with A5.
        for (int i = 0; i < 8; i++) tbl[i] = mk(1, 0, 0, i, i + 1, i == 7, 0, 0, 0, 0, 0, 0);
        tbl[8] = mk(1, 0, 0, 8, 8, 1, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) tbl[9 + i] = mk(0, 1, 0, 0, 7 - i, 0, i == 7, 1, 0, 1, i, i + 1);
        tbl[17] = mk(0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 7, 0);
        tbl[18] = mk(1, 0, 1, 32'hA5, 1, 0, 0, 0, 0, 0, 7, 32'hA5);
        tbl[19] = mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 32'hA5, 0);
        tbl[20] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'hA5, 0);

        do_reset(0);
        chk("reset reg_data", bus0.rd_data, 0);
        chk("reset afull", bus1.afull, 1'b0);
        chk("reset aempty", bus1.aempty, 1'b1);

        for (int k = 0; k < 21; k++) begin
            cycle(tbl[k].wr, tbl[k].wd, tbl[k].rd, tbl[k].clr);
            chk($sformatf("tbl%0d level", k), bus1.level, tbl[k].lvl);
            chk($sformatf("tbl%0d full", k), bus1.full, tbl[k].full);
            chk($sformatf("tbl%0d empty", k), bus1.empty, tbl[k].empty);
            chk($sformatf("tbl%0d ovf", k), bus1.overflow, tbl[k].ovf);
            chk($sformatf("tbl%0d unf", k), bus0.underflow, tbl[k].unf);
            chk($sformatf("tbl%0d rv0", k), bus0.rd_valid, tbl[k].rv0);
            chk($sformatf("tbl%0d rd0", k), bus0.rd_data, tbl[k].rd0);
            if (!tbl[k].empty) chk($sformatf("tbl%0d head", k), bus1.rd_data, tbl[k].head);
        end

        // Steady level 4 with simultaneous read/write; pointers wrap past 16.
        do_reset(0);
        for (int i = 0; i < 4; i++) cycle(1, 100 + i, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cycle(1, 200 + i, 1, 0);
            chk($sformatf("steady%0d level", i), bus1.level, 4);
        end

        // Thresholds: afull_th=0 forces afull, then 6/1 during a fill.
        do_reset(0);
        afull_th = 4'd0;
        #1 chk("afull_th0", {bus1.afull, bus0.afull}, 2'b11);
        afull_th = 4'd6; aempty_th = 4'd1;
        for (int k = 1; k <= 6; k++) begin
            cycle(1, 32'h300 + k, 0, 0);
            chk($sformatf("fill%0d aempty", k), bus1.aempty, k <= 1);
            chk($sformatf("fill%0d afull", k), bus1.afull, k >= 6);
        end
        afull_th = 4'd7;
        cycle(0, 0, 0, 0);
        chk("th7 afull", bus1.afull, 1'b0);
        cycle(1, 32'h307, 0, 0);
        chk("lvl7 afull", bus1.afull, 1'b1);
        cycle(1, 32'h308, 0, 0);
        chk("lvl8 full", bus1.full, 1'b1);

        // Write into full FIFO with same-cycle read, then clear-vs-set race.
        cycle(1, 77, 1, 0);
        chk("fullrw level", bus1.level, 7);
        chk("fullrw ovf", bus1.overflow, 1'b1);
        cycle(1, 78, 0, 1);
        chk("clr ovf", bus1.overflow, 1'b0);
        cycle(1, 79, 0, 1);
        chk("set beats clr", bus1.overflow, 1'b1);

        // Reset mid-burst at level 5.
        do_reset(0);
        for (int i = 0; i < 5; i++) cycle(1, 500 + i, 0, 0);
        cycle(0, 0, 0, 0);
`ifdef SYNC_FIFO_WMARK_EN
        chk("peak before reset", bus1.peak_level, 5);
`else
        chk("peak before reset", bus1.peak_level, 0);
`endif
        do_reset(1);

        // Randomized traffic with alternating fill/drain bias.
        for (int i = 0; i < 400; i++) begin
            int  bias;
            bit  w, r, c;
            bias = ((i / 50) % 2 == 0) ? 70 : 30;
            w = ($urandom_range(0, 99) < bias);
            r = ($urandom_range(0, 99) < (100 - bias));
            c = ($urandom_range(0, 15) == 0);
            if (i % 64 == 0) begin
                afull_th  = 4'($urandom_range(0, 9));
                aempty_th = 4'($urandom_range(0, 9));
            end
            cycle(w, $urandom, r, c);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (checks %0d)", checks);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
